supercar_scanner: RTL and testbench
===================================

// Module: supercar_scanner
// PURPOSE
//  Parametrised Knight-Rider light bar on NUM_DIGITS seven-segment digits; successor to the fixed 4-digit Supercar.
//  Adds run/pause, bounce/wrap mode, four speeds and a configurable trailing tail, all driven by board keys.
//  Sits at board top level, between CLOCK_50/KEY pins and HEX display pins.
// PARAMETERS
//  NUM_DIGITS   4            digits driven, >=1; digit 0 = HEX0 (rightmost)
//  STEP_CYCLES  25_000_000   clocks per step at speed 0, >=2
//  TAIL_LEN     2            trailing digits shown, 0..NUM_DIGITS-1
//  SEG_HEAD     7'b0111111   active-low pattern of head digit (segment g lit)
//  SEG_TAIL     7'b1110111   active-low pattern of tail digit (segment d lit)
// PORTS
//  CLOCK_50  in   1               single system clock, rising edge
//  KEY       in   4               active-low pushbuttons; KEY[0] = asynchronous active-low reset
//  HEX       out  7*NUM_DIGITS    active-low segments, digit i at [7*i+6:7*i]
// BEHAVIOUR
//  Reset: KEY[0]=0 asserts asynchronously; release synchronised by 2-FF chain (deassert 2 clocks after KEY[0] rises).
//  Reset state: pos=0, dir=UP (toward higher index), RUN, mode BOUNCE, speed=0, prescaler=0, tail history all invalid.
//  Reset outputs: HEX digit0=SEG_HEAD, all other digits 7'h7F.
//  Keys KEY[3:1]: each 2-FF synchronised; a press = synced 1->0 transition, one-cycle pulse; holding gives one pulse.
//   KEY[1] press: toggle RUN/PAUSE. PAUSE freezes prescaler, pos, dir, history; display held.
//   KEY[2] press: toggle BOUNCE/WRAP; takes effect at next step, pos/dir unchanged.
//   KEY[3] press: speed 0->1->2->3->0; prescaler cleared same cycle; period = STEP_CYCLES<<speed.
//  Prescaler: counts in RUN; at count==period-1 issues step and returns to 0.
//  Step (registered, same cycle as step pulse): history shifts in old pos; pos/dir update:
//   BOUNCE, UP:   pos<N-1 -> pos+1; pos==N-1 -> dir=DOWN, pos=N-2 (no dwell at end).
//   BOUNCE, DOWN: pos>0 -> pos-1; pos==0 -> dir=UP, pos=1.
//   WRAP: UP N-1->0, DOWN 0->N-1, dir never changes. Mode switch keeps dir.
//   NUM_DIGITS==1: pos stays 0, dir held, history still shifts.
//  Display: HEX registered, updated the cycle after pos/history change (1-clock latency).
//   digit==pos -> SEG_HEAD; else digit in valid history -> SEG_TAIL; else 7'h7F. Head wins over tail.
//  Simultaneous events: reset dominates all; same-cycle KEY[3] press and step -> speed change wins, no step;
//   KEY[1] press and step same cycle -> step applied, then pause.
//  Counter width $clog2((STEP_CYCLES<<3)); no overflow at speed 3.
// STRUCTURE
//  supercar_pkg: dir_t {UP,DOWN}, mode_t {BOUNCE,WRAP}, run_t {RUN,PAUSE}, SEG_BLANK=7'h7F.
//  Sub-module key_edge_sync: 2-FF synchroniser + falling-edge pulse; instantiated 3x for KEY[3:1].
//  Top holds reset synchroniser, prescaler, pos/dir FSM, tail history shift register, HEX decode.
// TESTING (NUM_DIGITS=4, STEP_CYCLES=4, TAIL_LEN=1, 10 ns clock)
//  1 Reset: KEY=4'b1110 then 4'b1111 -> HEX0=SEG_HEAD, HEX1..3=7'h7F; first step 4 clocks after sync release.
//  2 Bounce: free run -> head sequence 0,1,2,3,2,1,0,1; after pos 3->2, tail on digit 3.
//  3 Wrap: KEY[2] pulse at pos 2 moving UP -> 3,0,1; at 3->0 tail on digit 3, head on 0.
//  4 Pause: KEY[1] pulse at pos 1 -> HEX frozen 100 clocks; second pulse -> next step 4 clocks later.
//  5 Speed: three KEY[3] presses -> step every 32 clocks; fourth -> back to 4; held key gives one change.
//  6 Reset mid-run: KEY[0]=0 at pos 3 DOWN in WRAP, speed 2 -> immediate reset state, BOUNCE, speed 0.

Source files
------------

// File: rtl/supercar_scanner_pkg.sv
// Purpose : shared types and constants for the supercar scanner light bar.
// Latency : n/a (types only).
// Backpressure: n/a (types only).
package supercar_pkg;

  typedef enum logic {UP = 1'b0, DOWN = 1'b1} dir_t;      // UP = toward higher digit index
  typedef enum logic {BOUNCE = 1'b0, WRAP = 1'b1} mode_t;
  typedef enum logic {RUN = 1'b0, PAUSE = 1'b1} run_t;

  localparam logic [6:0] SEG_BLANK = 7'h7F;               // active-low, all segments dark

endpackage

// File: rtl/supercar_scanner_key_edge_sync.sv
// Purpose : 2-FF synchroniser for one active-low pushbutton plus press (1->0) detector.
// Latency : press pulse sampled 3 clocks after the pin falls; one pulse per press, however long held.
// Backpressure: none; pulse is a single cycle and is not held for a consumer.
// Ports   : clk, rst_n (async active-low), key (raw active-low pin), press (1-cycle pulse).
module key_edge_sync
  import supercar_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic key,
  output logic press
);

  logic s1;
  logic s2;
  logic s2_q;

  // Reset to "released" so a key that is idle across reset gives no pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1   <= 1'b1;
      s2   <= 1'b1;
      s2_q <= 1'b1;
    end else begin
      s1   <= key;
      s2   <= s1;
      s2_q <= s2;
    end
  end

  assign press = s2_q & ~s2;

endmodule

// File: rtl/supercar_scanner.sv
// Purpose : Knight-Rider light bar over NUM_DIGITS seven-segment digits with run/pause, bounce/wrap,
//           four speeds and a trailing tail, all controlled from board keys.
// Latency : HEX follows a position step by 1 clock; key actions land 3 clocks after the pin falls.
// Backpressure: none; free-running display, no handshake.
// Ports   : CLOCK_50 (clock), KEY[0] async active-low reset, KEY[1] run/pause, KEY[2] bounce/wrap,
//           KEY[3] speed; HEX active-low segments, digit i at [7*i+6:7*i], digit 0 rightmost.
module supercar_scanner
  import supercar_pkg::*;
#(
  parameter int          NUM_DIGITS  = 4,
  parameter int          STEP_CYCLES = 25_000_000,
  parameter int          TAIL_LEN    = 2,
  parameter logic [6:0]  SEG_HEAD    = 7'b0111111,
  parameter logic [6:0]  SEG_TAIL    = 7'b1110111
)(
  input  logic                    CLOCK_50,
  input  logic [3:0]              KEY,
  output logic [7*NUM_DIGITS-1:0] HEX
);

  localparam int CW = $clog2(STEP_CYCLES << 3);
  localparam int PW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int HL = (TAIL_LEN > 0) ? TAIL_LEN : 1;

  // Terminal counts for period = STEP_CYCLES << speed; only period-1 must fit in CW bits.
  localparam logic [CW-1:0] LAST0 = CW'(STEP_CYCLES - 1);
  localparam logic [CW-1:0] LAST1 = CW'((STEP_CYCLES << 1) - 1);
  localparam logic [CW-1:0] LAST2 = CW'((STEP_CYCLES << 2) - 1);
  localparam logic [CW-1:0] LAST3 = CW'((STEP_CYCLES << 3) - 1);
  localparam logic [PW-1:0] POS_MAX = PW'(NUM_DIGITS - 1);

  // Reset: asserts immediately with KEY[0], releases two clocks after KEY[0] rises.
  logic rs1;
  logic rs2;
  logic rst_n;

  always_ff @(posedge CLOCK_50 or negedge KEY[0]) begin
    if (!KEY[0]) begin
      rs1 <= 1'b0;
      rs2 <= 1'b0;
    end else begin
      rs1 <= 1'b1;
      rs2 <= rs1;
    end
  end

  assign rst_n = rs2;

  logic [3:1] press;

  for (genvar g = 1; g < 4; g++) begin : g_key
    key_edge_sync u_sync (
      .clk   (CLOCK_50),
      .rst_n (rst_n),
      .key   (KEY[g]),
      .press (press[g])
    );
  end

  logic run_press;
  logic mode_press;
  logic spd_press;

  assign run_press  = press[1];
  assign mode_press = press[2];
  assign spd_press  = press[3];

  run_t            run;
  mode_t           mode;
  logic [1:0]      speed;
  logic [CW-1:0]   cnt;
  logic [CW-1:0]   last;
  logic            step;

  always_comb begin
    last = LAST0;
    case (speed)
      2'd1:    last = LAST1;
      2'd2:    last = LAST2;
      2'd3:    last = LAST3;
      default: last = LAST0;
    endcase
  end

  // A speed change restarts the period, so it suppresses a step due in the same cycle.
  assign step = (run == RUN) && (cnt == last) && !spd_press;

  // A pause arriving with a step still lets that step through (run is sampled before toggling).
  always_ff @(posedge CLOCK_50 or negedge rst_n) begin
    if (!rst_n) begin
      run   <= RUN;
      mode  <= BOUNCE;
      speed <= 2'd0;
      cnt   <= '0;
    end else begin
      if (run_press)  run  <= (run == RUN) ? PAUSE : RUN;
      if (mode_press) mode <= (mode == BOUNCE) ? WRAP : BOUNCE;
      if (spd_press) begin
        speed <= speed + 2'd1;
        cnt   <= '0;
      end else if (run == RUN) begin
        cnt <= (cnt == last) ? '0 : cnt + 1'b1;
      end
    end
  end

  // Position / direction state machine.
  logic [PW-1:0] pos;
  logic [PW-1:0] pos_nxt;
  dir_t          dir;
  dir_t          dir_nxt;

  always_ff @(posedge CLOCK_50 or negedge rst_n) begin
    if (!rst_n) begin
      pos <= '0;
      dir <= UP;
    end else begin
      pos <= pos_nxt;
      dir <= dir_nxt;
    end
  end

  always_comb begin
    pos_nxt = pos;
    dir_nxt = dir;
    if (step && NUM_DIGITS > 1) begin
      if (mode == WRAP) begin
        if (dir == UP) pos_nxt = (pos == POS_MAX) ? '0 : pos + 1'b1;
        else           pos_nxt = (pos == '0) ? POS_MAX : pos - 1'b1;
      end else if (dir == UP) begin
        // No dwell at the ends: turn and move in the same step.
        if (pos == POS_MAX) begin
          dir_nxt = DOWN;
          pos_nxt = pos - 1'b1;
        end else begin
          pos_nxt = pos + 1'b1;
        end
      end else begin
        if (pos == '0) begin
          dir_nxt = UP;
          pos_nxt = PW'(1);
        end else begin
          pos_nxt = pos - 1'b1;
        end
      end
    end
  end

  // Tail history: entry 0 is the most recent previous head position.
  logic [PW-1:0] hist [HL];
  logic [HL-1:0] hist_vld;

  always_ff @(posedge CLOCK_50 or negedge rst_n) begin
    if (!rst_n) begin
      hist_vld <= '0;
      for (int j = 0; j < HL; j++) hist[j] <= '0;
    end else if (step) begin
      hist[0]     <= pos;
      hist_vld[0] <= 1'b1;
      for (int j = 1; j < HL; j++) begin
        hist[j]     <= hist[j-1];
        hist_vld[j] <= hist_vld[j-1];
      end
    end
  end

  // Digit decode; the head overrides any tail entry on the same digit.
  logic [7*NUM_DIGITS-1:0] hex_nxt;

  always_comb begin
    hex_nxt = '1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      hex_nxt[7*i +: 7] = SEG_BLANK;
      if (pos == PW'(i)) begin
        hex_nxt[7*i +: 7] = SEG_HEAD;
      end else begin
        for (int j = 0; j < TAIL_LEN; j++) begin
          if (hist_vld[j] && hist[j] == PW'(i)) hex_nxt[7*i +: 7] = SEG_TAIL;
        end
      end
    end
  end

  always_ff @(posedge CLOCK_50 or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_DIGITS; i++) HEX[7*i +: 7] <= (i == 0) ? SEG_HEAD : SEG_BLANK;
    end else begin
      HEX <= hex_nxt;
    end
  end

endmodule

// File: tb/tb_supercar_scanner.sv
// Purpose : self-checking bench for supercar_scanner (4 digits, 4-clock base step, 1-digit tail).
// Latency : expected HEX values are queued ahead of stimulus; a monitor pops one per HEX change.
// Backpressure: none; any HEX change with nothing queued is reported.
module tb_supercar_scanner;

  logic        clk;
  logic [3:0]  KEY;
  logic [27:0] HEX;

  supercar_scanner #(
    .NUM_DIGITS  (4),
    .STEP_CYCLES (4),
    .TAIL_LEN    (1)
  ) dut (
    .CLOCK_50 (clk),
    .KEY      (KEY),
    .HEX      (HEX)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [27:0] hex;
    int          gap;   // negedges since previous HEX change; 0 = not checked
    string       nm;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;
  bit   mon_en   = 1'b0;

  // Build an expected HEX word: head digit lit g (7'h3F), tail digit lit d (7'h77), rest dark.
  function automatic logic [27:0] mk(input int head, input int tail);
    logic [27:0] r;
    r = '1;
    if (tail >= 0) r[7*tail +: 7] = 7'h77;
    r[7*head +: 7] = 7'h3F;
    return r;
  endfunction

  task automatic push(input string nm, input int h, input int t, input int g);
    exp_t x;
    x.hex = mk(h, t);
    x.gap = g;
    x.nm  = nm;
    exp_q.push_back(x);
  endtask

  task automatic chk(input string nm, input logic [27:0] got, input logic [27:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got=%h want=%h", nm, got, want);
    end
  endtask

  // Monitor: every HEX change consumes one queued expectation.
  int          cyc  = 0;
  int          last = 0;
  logic [27:0] prev;
  exp_t        e;

  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (!mon_en) begin
        prev = HEX;
        last = cyc;
      end else if (HEX !== prev) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_change got=%h cycle=%0d", HEX, cyc);
        end else begin
          e = exp_q.pop_front();
          if (HEX !== e.hex) begin
            failures++;
            $display("FAIL %s got=%h want=%h", e.nm, HEX, e.hex);
          end
          if (e.gap != 0) begin
            checks++;
            if (cyc - last != e.gap) begin
              failures++;
              $display("FAIL %s_gap got=%0d want=%0d", e.nm, cyc - last, e.gap);
            end
          end
        end
        prev = HEX;
        last = cyc;
      end
    end
  end

  // Returns on the first posedge after the queue empties.
  task automatic wait_drain(input string nm);
    int n;
    n = 0;
    do begin
      @(posedge clk);
      n++;
    end while (exp_q.size() != 0 && n < 300);
    if (exp_q.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL %s_timeout got_pending=%0d want_pending=0", nm, exp_q.size());
      exp_q.delete();
    end
  endtask

  // Key falls on the k-th negedge, stays low for 'hold' negedges; action lands 3 clocks after the fall.
  task automatic press(input int idx, input int k, input int hold);
    repeat (k) @(negedge clk);
    KEY[idx] = 1'b0;
    repeat (hold) @(negedge clk);
    KEY[idx] = 1'b1;
  endtask

  initial begin
    KEY = 4'hF;
    repeat (3) @(negedge clk);

    // Reset state while KEY[0] is held low.
    KEY = 4'b1110;
    repeat (3) @(negedge clk);
    chk("reset_hex", HEX, mk(0, -1));

    // Bounce from reset. First change: release negedge + 2 sync clocks + 4 prescaler clocks
    // + 1 display clock, measured from the negedge before release -> 8.
    @(posedge clk);
    mon_en = 1'b1;
    push("b1", 1, 0, 8);
    push("b2", 2, 1, 4);
    push("b3", 3, 2, 4);
    push("b4_turn", 2, 3, 4);
    push("b5", 1, 2, 4);
    push("b6", 0, 1, 4);
    push("b7_turn", 1, 0, 4);
    push("b8", 2, 1, 4);
    @(negedge clk);
    KEY = 4'hF;
    wait_drain("bounce");

    // Wrap: mode toggle lands one clock after the 2->3 step, so 3 wraps to 0.
    push("w1", 3, 2, 4);
    press(2, 1, 1);
    wait_drain("wrap_a");

    // Pause press timed to land on the 0->1 step: step happens, then freeze with prescaler at 0.
    push("w2_wrap", 0, 3, 4);
    push("w3_pause_step", 1, 0, 4);
    press(1, 4, 1);
    wait_drain("pause");
    repeat (100) @(negedge clk);
    chk("pause_frozen", HEX, mk(1, 0));

    // Resume: 100 idle negedges + key fall + 3 sync clocks + 4 prescaler clocks + 1 display clock.
    push("resume", 2, 1, 109);
    press(1, 1, 1);
    wait_drain("resume");

    // Speed: one step at speed 0 slips in before the first press; three presses end at speed 3.
    push("s0", 3, 2, 4);
    push("s3_first", 0, 3, 37);
    push("s3_period", 1, 0, 32);
    press(3, 1, 1);
    press(3, 1, 1);
    press(3, 1, 1);
    wait_drain("speed3");

    // Fourth press held 40 clocks: exactly one change back to speed 0.
    for (int m = 0; m < 12; m++) push("held", (2 + m) % 4, (1 + m) % 4, (m == 0) ? 9 : 4);
    press(3, 1, 40);
    wait_drain("held");

    // Back to bounce so the head turns DOWN at digit 3.
    push("bb1", 2, 1, 4);
    push("bb2", 3, 2, 4);
    push("bb3_turn", 2, 3, 4);
    push("bb4", 1, 2, 4);
    press(2, 1, 1);
    wait_drain("rebounce");

    // Wrap while moving DOWN, then speed 2: 0 wraps to 3, 16-clock period from the last press.
    push("wd1", 0, 1, 4);
    push("wd2_wrap_down", 3, 0, 21);
    press(2, 1, 1);
    press(3, 1, 1);
    press(3, 1, 1);
    wait_drain("wrap_down");

    // Mid-run reset at pos 3, DOWN, WRAP, speed 2 -> reset state, then bounce UP at speed 0.
    push("mid_reset", 0, -1, 0);
    push("r1", 1, 0, 9);
    push("r2", 2, 1, 4);
    push("r3", 3, 2, 4);
    push("r4_bounce", 2, 3, 4);
    @(posedge clk);
    #2;
    KEY[0] = 1'b0;
    repeat (3) @(negedge clk);
    KEY[0] = 1'b1;
    wait_drain("mid_reset");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
